pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches an instruction, holds it for the back end,
// then advances pc by the decoder-selected target or traps on a misaligned one.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic [1:0]  next_pc_sel,
  input  logic [31:0] jal_imm,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_imm,
  input  logic        branch_taken,
  input  logic        exec_done,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        trap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    TRAP  = 2'b11
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] retired_r;
  logic        imem_req_r;
  logic        inst_valid_r;
  logic        trap_r;
  logic [31:0] target_s;
  logic        aligned_s;

  // Next-pc target from this cycle's decoder select and operands
  always_comb begin
    target_s = pc_r + PC_STEP;
    case (next_pc_sel)
      2'b00: target_s = pc_r + PC_STEP;
      2'b01: target_s = pc_r + jal_imm;
      2'b10: target_s = jalr_target & 32'hFFFF_FFFE;
      2'b11: begin
        if (branch_taken) begin
          target_s = pc_r + branch_imm;
        end else begin
          target_s = pc_r + PC_STEP;
        end
      end
      default: target_s = pc_r + PC_STEP;
    endcase
    aligned_s = (target_s[1:0] == 2'b00);
  end

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      retired_r    <= 32'h0000_0000;
      imem_req_r   <= 1'b0;
      inst_valid_r <= 1'b0;
      trap_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (run) begin
            state_r    <= FETCH;
            imem_req_r <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ready) begin
            inst_r       <= imem_rdata;
            state_r      <= EXEC;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            inst_valid_r <= 1'b0;
            if (aligned_s) begin
              pc_r       <= target_s;
              retired_r  <= retired_r + 32'd1;
              state_r    <= FETCH;
              imem_req_r <= 1'b1;
            end else begin
              // pc and retired keep the faulting instruction's values
              trap_r  <= 1'b1;
              state_r <= TRAP;
            end
          end
        end
        TRAP: begin
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
          trap_r       <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign pc         = pc_r;
  assign retired    = retired_r;
  assign trap       = trap_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [1:0]  next_pc_sel = 2'b00;
  logic [31:0] jal_imm = 32'h0;
  logic [31:0] jalr_target = 32'h0;
  logic [31:0] branch_imm = 32'h0;
  logic        branch_taken = 1'b0;
  logic        exec_done = 1'b0;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        trap;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .next_pc_sel(next_pc_sel), .jal_imm(jal_imm), .jalr_target(jalr_target),
    .branch_imm(branch_imm), .branch_taken(branch_taken), .exec_done(exec_done),
    .pc(pc), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  // Behavioural model: which phase the sequencer is in plus its architectural values
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_TRAP = 3;
  int          m_mode = M_IDLE;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_ret = 32'h0;
  logic        m_trap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target();
    logic [31:0] t;
    case (next_pc_sel)
      2'b01:   t = m_pc + jal_imm;
      2'b10:   t = {jalr_target[31:1], 1'b0};
      2'b11:   t = branch_taken ? m_pc + branch_imm : m_pc + 32'd4;
      default: t = m_pc + 32'd4;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_inst = 32'h0; m_ret = 32'h0; m_trap = 1'b0;
  endtask

  task automatic model_clock();
    logic [31:0] t;
    if (m_mode == M_IDLE) begin
      if (run) m_mode = M_FETCH;
    end else if (m_mode == M_FETCH) begin
      if (imem_ready) begin m_inst = imem_rdata; m_mode = M_EXEC; end
    end else if (m_mode == M_EXEC) begin
      if (exec_done) begin
        t = model_target();
        if (t % 4 == 0) begin m_pc = t; m_ret = m_ret + 32'd1; m_mode = M_FETCH; end
        else begin m_trap = 1'b1; m_mode = M_TRAP; end
      end
    end
  endtask

  task automatic compare_all();
    chk1("imem_req", imem_req, m_mode == M_FETCH);
    chk1("inst_valid", inst_valid, m_mode == M_EXEC);
    chk1("trap", trap, m_trap);
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    if (m_mode == M_FETCH) chk("imem_addr", imem_addr, m_pc);
    if (m_mode == M_EXEC) chk("inst", inst, m_inst);
  endtask

  // One clock: model advances on the same edge the DUT samples, outputs checked at negedge
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    run = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_trap", trap, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_retired", retired, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    imem_ready = 1'b0;
    repeat (waits) step();
    imem_ready = 1'b1; imem_rdata = word;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic do_exec(input logic [1:0] sel, input logic [31:0] op, input logic taken);
    next_pc_sel = sel; jal_imm = op; jalr_target = op; branch_imm = op; branch_taken = taken;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  int trap_cycles;

  initial begin
    do_reset();

    // First instruction: fetch at 0 with ready on the third cycle
    run = 1'b1; step(); run = 1'b0;
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    do_fetch(32'h0000_0013, 2);
    chk("first_inst", inst, 32'h0000_0013);
    chk1("first_valid", inst_valid, 1'b1);
    do_exec(2'b00, 32'h0, 1'b0);
    chk("second_addr", imem_addr, 32'h4);
    chk("retired_one", retired, 32'h1);

    do_fetch(32'h1111_1111, 0); do_exec(2'b10, 32'h0000_0100, 1'b0);
    do_fetch(32'h2222_2222, 1); do_exec(2'b01, 32'hFFFF_FFF0, 1'b0);
    chk("jal_back", imem_addr, 32'h0000_00F0);
    do_fetch(32'h3333_3333, 0); do_exec(2'b10, 32'h0000_2001, 1'b0);
    chk("jalr_mask", pc, 32'h0000_2000);
    chk1("jalr_notrap", trap, 1'b0);
    do_fetch(32'h4, 0); do_exec(2'b10, 32'h0000_0010, 1'b0);
    do_fetch(32'h5, 0); do_exec(2'b11, 32'h0000_0040, 1'b0);
    chk("br_not_taken", pc, 32'h0000_0014);
    do_fetch(32'h6, 0); do_exec(2'b11, 32'h0000_0040, 1'b1);
    chk("br_taken", pc, 32'h0000_0054);
    do_fetch(32'h7, 0); do_exec(2'b10, 32'hFFFF_FFFC, 1'b0);
    do_fetch(32'h8, 0); do_exec(2'b00, 32'h0, 1'b0);
    chk("pc_wrap", pc, 32'h0);
    chk("retired_nine", retired, 32'd9);
    do_fetch(32'h9, 0); do_exec(2'b01, 32'h0000_0002, 1'b0);
    chk1("misalign_trap", trap, 1'b1);
    chk("misalign_pc", pc, 32'h0);
    chk("misalign_ret", retired, 32'd9);
    imem_ready = 1'b1; run = 1'b1; exec_done = 1'b1;
    repeat (3) step();
    chk1("trap_no_req", imem_req, 1'b0);
    chk1("trap_sticky", trap, 1'b1);

    // Reset abandons a pending fetch, then a pending execute
    do_reset();
    run = 1'b1; step(); run = 1'b0;
    do_reset();
    run = 1'b1; step(); run = 1'b0;
    do_fetch(32'hABCD_0000, 0);
    do_reset();
    chk("abandon_ret", retired, 32'h0);

    // Randomized traffic against the model
    trap_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      run          = ($urandom_range(0, 2) == 0);
      imem_ready   = $urandom_range(0, 1) == 1;
      imem_rdata   = $urandom;
      exec_done    = $urandom_range(0, 1) == 1;
      next_pc_sel  = 2'($urandom_range(0, 3));
      branch_taken = $urandom_range(0, 1) == 1;
      jal_imm      = $urandom;
      jalr_target  = $urandom;
      branch_imm   = $urandom;
      if ($urandom_range(0, 19) != 0) begin
        jal_imm[1:0] = 2'b00; jalr_target[1] = 1'b0; branch_imm[1:0] = 2'b00;
      end
      trap_cycles = (m_mode == M_TRAP) ? trap_cycles + 1 : 0;
      if (trap_cycles > 3 || $urandom_range(0, 399) == 0) begin
        do_reset();
        trap_cycles = 0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
